// File: rtl/vscale_regfile_sb_pkg.sv
// Shared widths for the vscale register file and its long-latency scoreboard.
package vscale_regfile_sb_pkg;
    localparam int XPR_LEN        = 32;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int DEF_MAX_OUT    = 4;
endpackage

// File: rtl/vscale_scoreboard.sv
// Tracks registers awaiting long-latency results, the outstanding-op count and protocol errors.
module vscale_scoreboard
    import vscale_regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ZERO_REG = 1,
    parameter int MAX_OUT  = DEF_MAX_OUT,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int CW       = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_addr,
    output logic                issue_ready,
    input  logic                wb_fire,
    input  logic [AW-1:0]       wb_addr,
    input  logic                wa_write,
    input  logic [AW-1:0]       wa_addr,
    output logic [NUM_REGS-1:0] pending,
    output logic [CW-1:0]       outstanding,
    output logic                sb_err
);
    logic [NUM_REGS-1:0] pending_reg;
    logic [CW-1:0]       outstanding_reg;
    logic                sb_err_reg;
    logic                issue_fire;
    logic                issue_counted;
    logic                wb_retire;
    logic                wb_stray;
    logic                wa_waw;
    logic                wb_to_zero;

    assign issue_ready   = !pending_reg[issue_addr] && (outstanding_reg < CW'(MAX_OUT));
    assign issue_fire    = issue_valid && issue_ready;
    assign issue_counted = issue_fire && !((ZERO_REG != 0) && (issue_addr == '0));
    assign wb_to_zero    = (ZERO_REG != 0) && (wb_addr == '0);
    assign wb_retire     = wb_fire && pending_reg[wb_addr];
    // A dropped write to the hard-wired zero register is not a protocol violation.
    assign wb_stray      = wb_fire && !pending_reg[wb_addr] && !wb_to_zero;
    assign wa_waw        = wa_write && pending_reg[wa_addr];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_counted && (issue_addr == AW'(gi));
            assign clr_bit = wb_fire && (wb_addr == AW'(gi));
            always_ff @(posedge clk) begin
                if (reset) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= set_bit | (pending_reg[gi] & ~clr_bit);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_reg <= '0;
            sb_err_reg      <= 1'b0;
        end else begin
            case ({issue_counted, wb_retire})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
            if (wb_stray || wa_waw) begin
                sb_err_reg <= 1'b1;
            end
        end
    end

    assign pending     = pending_reg;
    assign outstanding = outstanding_reg;
    assign sb_err      = sb_err_reg;
endmodule

// File: rtl/vscale_regfile_sb.sv
// Register file with pipeline write port A, handshaked long-latency port B, bypassed reads and scoreboard.
module vscale_regfile_sb
    import vscale_regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = XPR_LEN,
    parameter int NUM_REGS   = REG_COUNT,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int MAX_OUT    = DEF_MAX_OUT,
    parameter int AW         = $clog2(NUM_REGS),
    parameter int CW         = $clog2(MAX_OUT + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*AW-1:0]       rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]          rd_pending,
    input  logic                         wa_en,
    input  logic [AW-1:0]                wa_addr,
    input  logic [DATA_WIDTH-1:0]        wa_data,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [AW-1:0]                wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [AW-1:0]                issue_addr,
    output logic [CW-1:0]                outstanding,
    output logic                         sb_err
);
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic                  wa_write;
    logic                  wb_fire;
    logic                  wb_write;

    // Port A owns the array whenever it performs a real write, so port B waits.
    assign wa_write = (ZERO_REG != 0) ? (wa_en && (wa_addr != '0)) : wa_en;
    assign wb_ready = !wa_write;
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_write = wb_fire && !((ZERO_REG != 0) && (wb_addr == '0));

    always_ff @(posedge clk) begin
        if (wa_write) begin
            mem[wa_addr] <= wa_data;
        end else if (wb_write) begin
            mem[wb_addr] <= wb_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [AW-1:0]         addr;
            logic [DATA_WIDTH-1:0] data;
            assign addr = rd_addr[gi*AW +: AW];
            always_comb begin
                data = mem[addr];
                if ((ZERO_REG != 0) && (addr == '0)) begin
                    data = '0;
                end else if (wa_write && (wa_addr == addr)) begin
                    data = wa_data;
                end else if (wb_write && (wb_addr == addr)) begin
                    data = wb_data;
                end
            end
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data;
            assign rd_pending[gi] = pending[addr] && !(wb_fire && (wb_addr == addr));
        end
    endgenerate

    vscale_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .MAX_OUT  (MAX_OUT),
        .AW       (AW),
        .CW       (CW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .wb_fire     (wb_fire),
        .wb_addr     (wb_addr),
        .wa_write    (wa_write),
        .wa_addr     (wa_addr),
        .pending     (pending),
        .outstanding (outstanding),
        .sb_err      (sb_err)
    );
endmodule

// File: tb/tb_vscale_regfile_sb.sv
// Directed self-checking bench for vscale_regfile_sb with default parameters.
module tb_vscale_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_pending;
    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          issue_valid;
    logic          issue_ready;
    logic [AW-1:0] issue_addr;
    logic [CW-1:0] outstanding;
    logic          sb_err;

    int n_cmp = 0;
    int n_err = 0;

    vscale_regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_addr  (issue_addr),
        .outstanding (outstanding),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge, then settle 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check_val("reset_outstanding", 64'(outstanding), 64'd0);
        check_val("reset_sb_err", 64'(sb_err), 64'd0);
        check_val("reset_wb_ready", 64'(wb_ready), 64'd1);
        check_val("reset_issue_ready", 64'(issue_ready), 64'd1);
        check_val("reset_rd_pending", 64'(rd_pending), 64'd0);

        // Port A write with same-cycle bypass, then array read
        set_rd(5'd5, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        #1;
        check_val("x5_bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step();
        wa_en = 1'b0;
        #1;
        check_val("x5_array", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // Issue x7, then return it through port B
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        check_val("x7_issue_ready", 64'(issue_ready), 64'd1);
        step();
        issue_valid = 1'b0;
        set_rd(5'd7, 5'd5);
        #1;
        check_val("x7_pending", 64'(rd_pending), 64'b01);
        check_val("x7_outstanding", 64'(outstanding), 64'd1);
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
        #1;
        check_val("x7_wb_ready", 64'(wb_ready), 64'd1);
        check_val("x7_wb_bypass", 64'(rd_data[31:0]), 64'h12345678);
        check_val("x7_pending_cleared", 64'(rd_pending), 64'b00);
        check_val("x5_port1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        step();
        wb_valid = 1'b0;
        #1;
        check_val("x7_outstanding_after", 64'(outstanding), 64'd0);
        check_val("x7_array", 64'(rd_data[31:0]), 64'h12345678);

        // Port A priority over port B
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        issue_valid = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h33333333;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99999999;
        #1;
        check_val("arb_wb_blocked", 64'(wb_ready), 64'd0);
        step();
        wa_en = 1'b0;
        #1;
        check_val("arb_wb_accept", 64'(wb_ready), 64'd1);
        step();
        wb_valid = 1'b0;
        set_rd(5'd3, 5'd9);
        #1;
        check_val("arb_x3", 64'(rd_data[31:0]), 64'h33333333);
        check_val("arb_x9", 64'(rd_data[63:32]), 64'h99999999);
        check_val("arb_outstanding", 64'(outstanding), 64'd0);
        check_val("arb_sb_err", 64'(sb_err), 64'd0);

        // Fill the scoreboard to MAX_OUT
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_addr = AW'(11 + i);
            step();
        end
        issue_addr = 5'd15;
        #1;
        check_val("full_outstanding", 64'(outstanding), 64'd4);
        check_val("full_issue_ready", 64'(issue_ready), 64'd0);
        step();
        check_val("full_held", 64'(outstanding), 64'd4);
        wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'h0000000B;
        #1;
        check_val("full_ready_during_retire", 64'(issue_ready), 64'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check_val("after_retire_outstanding", 64'(outstanding), 64'd3);
        check_val("after_retire_ready", 64'(issue_ready), 64'd1);
        step();
        issue_valid = 1'b0;
        set_rd(5'd15, 5'd11);
        #1;
        check_val("fifth_outstanding", 64'(outstanding), 64'd4);
        check_val("fifth_pending", 64'(rd_pending), 64'b01);
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = AW'(12 + i); wb_data = 32'(i);
            step();
        end
        wb_valid = 1'b0;
        #1;
        check_val("drain_outstanding", 64'(outstanding), 64'd0);
        check_val("drain_sb_err", 64'(sb_err), 64'd0);

        // Stray return sets a sticky error
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hA5A5A5A5;
        step();
        wb_valid = 1'b0;
        #1;
        check_val("stray_sb_err", 64'(sb_err), 64'd1);
        check_val("stray_outstanding", 64'(outstanding), 64'd0);
        issue_valid = 1'b1; issue_addr = 5'd20;
        step();
        issue_valid = 1'b0;
        step();
        set_rd(5'd20, 5'd0);
        #1;
        check_val("stray_sticky", 64'(sb_err), 64'd1);
        check_val("x20_pending", 64'(rd_pending), 64'b01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("rst_sb_err", 64'(sb_err), 64'd0);
        check_val("rst_outstanding", 64'(outstanding), 64'd0);
        check_val("rst_pending", 64'(rd_pending), 64'b00);

        // Register zero on both ports and as an issue target
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        set_rd(5'd0, 5'd0);
        #1;
        check_val("x0_wb_ready", 64'(wb_ready), 64'd1);
        check_val("x0_bypass", 64'(rd_data), 64'd0);
        step();
        wa_en = 1'b0; wb_valid = 1'b0;
        #1;
        check_val("x0_array", 64'(rd_data), 64'd0);
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        check_val("x0_issue_ready", 64'(issue_ready), 64'd1);
        step();
        issue_valid = 1'b0;
        #1;
        check_val("x0_outstanding", 64'(outstanding), 64'd0);
        check_val("x0_pending", 64'(rd_pending), 64'b00);

        // Port A write to a pending register (WAW)
        issue_valid = 1'b1; issue_addr = 5'd21;
        step();
        issue_valid = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd21; wa_data = 32'h21212121;
        step();
        wa_en = 1'b0;
        set_rd(5'd21, 5'd21);
        #1;
        check_val("waw_sb_err", 64'(sb_err), 64'd1);
        check_val("waw_pending", 64'(rd_pending), 64'b11);
        check_val("waw_data", 64'(rd_data[31:0]), 64'h21212121);
        check_val("waw_outstanding", 64'(outstanding), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
